// File: rtl/dso_trig_ctrl_if.sv
// Sample-in / RAM-write bus between the ADC front end, the trigger sequencer and the waveform RAM.
// The slave side is the sequencer; the master side is the ADC source plus RAM sink.
interface dso_trig_ctrl_if;
    logic [7:0]  ad_data;
    logic        ad_data_vld;
    logic        ad_buf_wr;
    logic [11:0] ad_buf_wr_addr;
    logic [7:0]  ad_buf_data;

    modport master (
        output ad_data, ad_data_vld,
        input  ad_buf_wr, ad_buf_wr_addr, ad_buf_data
    );

    modport slave (
        input  ad_data, ad_data_vld,
        output ad_buf_wr, ad_buf_wr_addr, ad_buf_data
    );
endinterface

// File: rtl/dso_trig_ctrl.sv
// DSO trigger/capture sequencer: writes a pre/post-trigger window into a circular sample RAM,
// freezes it until the display has drawn the frame, and publishes the window start address.
module dso_trig_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int PRE_TRIG = 512,
    parameter int AUTO_TO  = 1048576
) (
    input  logic              ad_clk,
    input  logic              rst,
    dso_trig_ctrl_if.slave    bus,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    input  logic [1:0]        trig_mode,
    input  logic              arm,
    input  logic              frame_done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              buf_ready,
    output logic              auto_trig,
    output logic [2:0]        state
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam int CNT_W  = $clog2(AUTO_TO + 1);
    localparam bit PRE_ZERO  = (PRE_TRIG == 0);
    localparam bit POST_ZERO = (POST_N == 0);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_N > 0) ? POST_N - 1 : 0);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
    localparam logic [CNT_W-1:0]  AUTO_LAST = CNT_W'(AUTO_TO - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_HOLD  = 3'd4
    } st_e;

    st_e               st_q, st_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [CNT_W-1:0]  auto_cnt_q, auto_cnt_d;
    logic [7:0]        prev_q, prev_d;
    logic              has_prev_q, has_prev_d;
    logic [7:0]        lvl_q, lvl_d;
    logic              edge_q, edge_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              buf_ready_q, buf_ready_d;
    logic              auto_trig_q, auto_trig_d;

    logic writing_s;
    logic hit_s;
    logic timeout_s;

    // Next-state, pointer, counter and write-port logic.
    always_comb begin
        st_d        = st_q;
        ptr_d       = ptr_q;
        pre_cnt_d   = '0;
        post_cnt_d  = '0;
        auto_cnt_d  = '0;
        prev_d      = prev_q;
        has_prev_d  = has_prev_q;
        lvl_d       = lvl_q;
        edge_d      = edge_q;
        wr_d        = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        trig_addr_d = trig_addr_q;
        auto_trig_d = auto_trig_q;

        // POST only writes when the window actually has post-trigger room.
        writing_s = bus.ad_data_vld &&
                    ((st_q == ST_PRE) || (st_q == ST_ARMED) || ((st_q == ST_POST) && !POST_ZERO));
        hit_s     = has_prev_q &&
                    (edge_q ? ((prev_q > lvl_q) && (bus.ad_data <= lvl_q))
                            : ((prev_q < lvl_q) && (bus.ad_data >= lvl_q)));
        timeout_s = (trig_mode == 2'd0) && (auto_cnt_q == AUTO_LAST);

        if (writing_s) begin
            wr_d       = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = bus.ad_data;
            ptr_d      = ptr_q + 1'b1;
            prev_d     = bus.ad_data;
            has_prev_d = 1'b1;
        end else begin
            wr_d = 1'b0;
        end

        case (st_q)
            ST_IDLE: begin
                has_prev_d = 1'b0;
                if ((trig_mode != 2'd2) || arm) begin
                    st_d   = ST_PRE;
                    lvl_d  = trig_level;
                    edge_d = trig_edge;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (PRE_ZERO) begin
                    st_d = ST_ARMED;
                end else if (bus.ad_data_vld) begin
                    if (pre_cnt_q == PRE_LAST) begin
                        st_d = ST_ARMED;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q;
                end
            end
            ST_ARMED: begin
                auto_cnt_d = auto_cnt_q;
                if (bus.ad_data_vld) begin
                    if (hit_s || timeout_s) begin
                        st_d        = ST_POST;
                        trig_addr_d = ptr_q - PRE_OFS;
                        // A genuine edge on the timeout sample is reported as a real trigger.
                        auto_trig_d = !hit_s;
                    end else if (auto_cnt_q != AUTO_LAST) begin
                        auto_cnt_d = auto_cnt_q + 1'b1;
                    end else begin
                        auto_cnt_d = auto_cnt_q;
                    end
                end else begin
                    auto_cnt_d = auto_cnt_q;
                end
            end
            ST_POST: begin
                if (POST_ZERO) begin
                    st_d = ST_HOLD;
                end else if (bus.ad_data_vld) begin
                    if (post_cnt_q == POST_LAST) begin
                        st_d = ST_HOLD;
                    end else begin
                        post_cnt_d = post_cnt_q + 1'b1;
                    end
                end else begin
                    post_cnt_d = post_cnt_q;
                end
            end
            ST_HOLD: begin
                has_prev_d = 1'b0;
                if (frame_done) begin
                    if (trig_mode == 2'd2) begin
                        st_d = ST_IDLE;
                    end else begin
                        st_d   = ST_PRE;
                        lvl_d  = trig_level;
                        edge_d = trig_edge;
                    end
                end else begin
                    st_d = ST_HOLD;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase

        buf_ready_d = (st_d == ST_HOLD);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge ad_clk) begin
        if (rst) begin
            st_q        <= ST_IDLE;
            ptr_q       <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            auto_cnt_q  <= '0;
            prev_q      <= 8'h00;
            has_prev_q  <= 1'b0;
            lvl_q       <= 8'h00;
            edge_q      <= 1'b0;
            wr_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            trig_addr_q <= '0;
            buf_ready_q <= 1'b0;
            auto_trig_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            ptr_q       <= ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            auto_cnt_q  <= auto_cnt_d;
            prev_q      <= prev_d;
            has_prev_q  <= has_prev_d;
            lvl_q       <= lvl_d;
            edge_q      <= edge_d;
            wr_q        <= wr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            trig_addr_q <= trig_addr_d;
            buf_ready_q <= buf_ready_d;
            auto_trig_q <= auto_trig_d;
        end
    end

    assign bus.ad_buf_wr      = wr_q;
    assign bus.ad_buf_wr_addr = {{(12 - ADDR_W){1'b0}}, wr_addr_q};
    assign bus.ad_buf_data    = wr_data_q;
    assign trig_addr          = trig_addr_q;
    assign buf_ready          = buf_ready_q;
    assign auto_trig          = auto_trig_q;
    assign state              = st_q;

endmodule

// File: tb/tb_dso_trig_ctrl.sv
// Directed bench for dso_trig_ctrl: u1 (PRE_TRIG=512, AUTO_TO=16) and u2 (PRE_TRIG=0) share stimulus;
// expected RAM writes are queued per instance and checked by independent monitors.
module tb_dso_trig_ctrl;

    logic       ad_clk = 1'b0;
    logic       rst  = 1'b1;
    logic       rst2 = 1'b1;
    logic [7:0] ad_data = 8'h00;
    logic       ad_data_vld = 1'b0;
    logic [7:0] trig_level = 8'h80;
    logic       trig_edge = 1'b0;
    logic [1:0] trig_mode = 2'd1;
    logic       arm = 1'b0;
    logic       frame_done = 1'b0;

    logic [9:0] trig_addr1, trig_addr2;
    logic       buf_ready1, buf_ready2, auto_trig1, auto_trig2;
    logic [2:0] state1, state2;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
        logic        win;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   sel = 1;
    logic [9:0] eptr1 = 10'd0;
    logic [9:0] eptr2 = 10'd0;
    int   wcnt[1024];

    always #5 ad_clk = ~ad_clk;

    dso_trig_ctrl_if bus1 ();
    dso_trig_ctrl_if bus2 ();
    assign bus1.ad_data     = ad_data;
    assign bus1.ad_data_vld = ad_data_vld;
    assign bus2.ad_data     = ad_data;
    assign bus2.ad_data_vld = ad_data_vld;

    dso_trig_ctrl #(.ADDR_W(10), .PRE_TRIG(512), .AUTO_TO(16)) u1 (
        .ad_clk(ad_clk), .rst(rst), .bus(bus1),
        .trig_level(trig_level), .trig_edge(trig_edge), .trig_mode(trig_mode),
        .arm(arm), .frame_done(frame_done),
        .trig_addr(trig_addr1), .buf_ready(buf_ready1), .auto_trig(auto_trig1), .state(state1)
    );

    dso_trig_ctrl #(.ADDR_W(10), .PRE_TRIG(0), .AUTO_TO(16)) u2 (
        .ad_clk(ad_clk), .rst(rst2), .bus(bus2),
        .trig_level(trig_level), .trig_edge(trig_edge), .trig_mode(trig_mode),
        .arm(arm), .frame_done(frame_done),
        .trig_addr(trig_addr2), .buf_ready(buf_ready2), .auto_trig(auto_trig2), .state(state2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ad_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic win);
        if (sel == 1) begin
            q1.push_back({2'b00, eptr1, d, win});
            eptr1 = eptr1 + 10'd1;
        end else begin
            q2.push_back({2'b00, eptr2, d, win});
            eptr2 = eptr2 + 10'd1;
        end
        ad_data     = d;
        ad_data_vld = 1'b1;
        step();
        ad_data_vld = 1'b0;
    endtask

    task automatic nowr(input logic [7:0] d);
        ad_data     = d;
        ad_data_vld = 1'b1;
        step();
        ad_data_vld = 1'b0;
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic rst_chk(input string name);
        chk(name, {state1, buf_ready1, auto_trig1, bus1.ad_buf_wr, trig_addr1,
                   bus1.ad_buf_wr_addr, bus1.ad_buf_data}, 64'd0);
    endtask

    // Monitor for u1 RAM writes against the expected queue.
    always @(negedge ad_clk) begin
        if (bus1.ad_buf_wr === 1'b1) begin
            exp_t e;
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr1_unexpected addr=%0d data=0x%0h", bus1.ad_buf_wr_addr, bus1.ad_buf_data);
            end else begin
                e = q1.pop_front();
                chk("wr1_addr_data", {bus1.ad_buf_wr_addr, bus1.ad_buf_data}, {e.addr, e.data});
            end
        end
    end

    // Monitor for u2 RAM writes; also counts per-address writes inside the trigger window.
    always @(negedge ad_clk) begin
        if (bus2.ad_buf_wr === 1'b1) begin
            exp_t e;
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr2_unexpected addr=%0d data=0x%0h", bus2.ad_buf_wr_addr, bus2.ad_buf_data);
            end else begin
                e = q2.pop_front();
                chk("wr2_addr_data", {bus2.ad_buf_wr_addr, bus2.ad_buf_data}, {e.addr, e.data});
                if (e.win) wcnt[int'(bus2.ad_buf_wr_addr[9:0])]++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        // Reset state
        step();
        step();
        rst_chk("reset_state");

        // Normal mode, rising through 0x80 on a ramp
        rst = 1'b0;
        step();
        chk("pre_entry", state1, 3'd1);
        sel = 1;
        eptr1 = 10'd0;
        for (int i = 0; i < 1152; i++) wr(8'(i), 1'b0);
        chk("ramp_hold", state1, 3'd4);
        chk("ramp_ready", buf_ready1, 1'b1);
        chk("ramp_trig_addr", trig_addr1, 10'd128);
        chk("ramp_auto", auto_trig1, 1'b0);
        for (int i = 0; i < 4; i++) nowr(8'hAA);
        chk("hold_stays", state1, 3'd4);

        // Auto mode: forced trigger on the 16th ARMED sample
        trig_mode = 2'd0;
        pulse_fd();
        chk("auto1_pre", state1, 3'd1);
        chk("ready_drop", buf_ready1, 1'b0);
        eptr1 = 10'd128;
        for (int i = 0; i < 528 + 511; i++) wr(8'h10, 1'b0);
        chk("auto1_hold", state1, 3'd4);
        chk("auto1_trig_addr", trig_addr1, 10'd143);
        chk("auto1_flag", auto_trig1, 1'b1);

        // Auto mode with a real edge on the timeout sample
        pulse_fd();
        eptr1 = 10'd143;
        for (int i = 0; i < 527; i++) wr(8'h10, 1'b0);
        wr(8'h90, 1'b0);
        for (int i = 0; i < 511; i++) wr(8'h10, 1'b0);
        chk("auto2_hold", state1, 3'd4);
        chk("auto2_trig_addr", trig_addr1, 10'd158);
        chk("auto2_flag", auto_trig1, 1'b0);

        // Falling edge at 0x40, with a 7-cycle vld gap in PRE
        trig_mode  = 2'd1;
        trig_level = 8'h40;
        trig_edge  = 1'b1;
        pulse_fd();
        eptr1 = 10'd158;
        for (int i = 0; i < 300; i++) wr(8'h40, 1'b0);
        repeat (7) step();
        for (int i = 0; i < 211; i++) wr(8'h40, 1'b0);
        chk("gap_still_pre", state1, 3'd1);
        wr(8'h40, 1'b0);
        chk("gap_armed", state1, 3'd2);
        for (int i = 0; i < 20; i++) wr(8'h40, 1'b0);
        chk("const_no_trig", state1, 3'd2);
        wr(8'h50, 1'b0);
        wr(8'h40, 1'b0);
        chk("fall_trig", state1, 3'd3);
        for (int i = 0; i < 511; i++) wr(8'h40, 1'b0);
        chk("fall_hold", state1, 3'd4);
        chk("fall_trig_addr", trig_addr1, 10'd179);

        // Single mode
        trig_mode  = 2'd2;
        trig_level = 8'h80;
        trig_edge  = 1'b0;
        pulse_fd();
        chk("single_idle", state1, 3'd0);
        for (int i = 0; i < 20; i++) nowr(8'h90);
        chk("single_wait", state1, 3'd0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("single_arm", state1, 3'd1);
        eptr1 = 10'd179;
        for (int i = 0; i < 512; i++) begin
            frame_done = (i == 100);
            arm        = (i == 100);
            wr(8'h00, 1'b0);
            frame_done = 1'b0;
            arm        = 1'b0;
        end
        wr(8'h00, 1'b0);
        wr(8'h80, 1'b0);
        for (int i = 0; i < 511; i++) wr(8'h22, 1'b0);
        chk("single_hold", state1, 3'd4);
        chk("single_ready", buf_ready1, 1'b1);
        chk("single_trig_addr", trig_addr1, 10'd180);
        pulse_fd();
        chk("single_back_idle", state1, 3'd0);
        chk("single_ready_drop", buf_ready1, 1'b0);
        for (int i = 0; i < 10; i++) nowr(8'h90);
        chk("single_no_rearm", state1, 3'd0);

        // Reset pulse during POST
        trig_mode = 2'd1;
        step();
        chk("rst_test_pre", state1, 3'd1);
        eptr1 = 10'd180;
        for (int i = 0; i < 512; i++) wr(8'h00, 1'b0);
        wr(8'h80, 1'b0);
        for (int i = 0; i < 10; i++) wr(8'h33, 1'b0);
        chk("rst_test_post", state1, 3'd3);
        chk("rst_test_trig_addr", trig_addr1, 10'd180);
        rst = 1'b1;
        step();
        rst_chk("post_reset");
        rst = 1'b0;
        step();
        eptr1 = 10'd0;
        wr(8'h44, 1'b0);
        wr(8'h45, 1'b0);
        rst = 1'b1;
        step();

        // Wrap with PRE_TRIG = 0 on u2: first capture leaves ptr at 1000
        sel  = 2;
        rst2 = 1'b0;
        step();
        chk("wrap_pre", state2, 3'd1);
        step();
        chk("wrap_armed_next", state2, 3'd2);
        eptr2 = 10'd0;
        for (int i = 0; i < 1000; i++) wr(8'h10, 1'b0);
        wr(8'h90, 1'b0);
        chk("wrap1_trig_addr", trig_addr2, 10'd1000);
        for (int i = 0; i < 1023; i++) wr(8'(i), 1'b0);
        chk("wrap1_hold", state2, 3'd4);
        pulse_fd();
        chk("wrap2_pre", state2, 3'd1);
        step();
        chk("wrap2_armed", state2, 3'd2);
        for (int a = 0; a < 1024; a++) wcnt[a] = 0;
        eptr2 = 10'd1000;
        wr(8'h10, 1'b0);
        wr(8'h90, 1'b1);
        chk("wrap2_trig_addr", trig_addr2, 10'd1001);
        for (int i = 0; i < 1023; i++) wr(8'(i + 5), 1'b1);
        chk("wrap2_hold", state2, 3'd4);
        step();
        step();
        bad = 0;
        for (int a = 0; a < 1024; a++) if (wcnt[a] != 1) bad++;
        chk("wrap_each_addr_once", bad, 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
